// File: rtl/ram_4k_req_sched.sv
// ram_4k_req_sched
//   Request front-end for ram_4k. Accepts independent valid/ready write and
//   read requests and drives ram_4k's write and read ports with registered
//   strobes, so at most one write and one read go out per cycle. Read data
//   comes back on ram_data_out/ram_data_valid one cycle after ram_read. It is
//   captured into a small response FIFO and presented on rsp_valid/rsp_ready.
//   The read credit counts both in-flight reads and FIFO entries, so the FIFO
//   can never overflow. Response backpressure stalls reads but never writes.
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   wr_req_valid/ready/addr/data     write request channel
//   rd_req_valid/ready/addr          read request channel
//   rsp_valid/ready/data             read response channel (FIFO head)
//   ram_data_in, ram_wr_address,
//   ram_write                        ram_4k write port (registered)
//   ram_rd_address, ram_read         ram_4k read port (registered)
//   ram_data_out, ram_data_valid     ram_4k read return
//   err_stray_valid                  sticky: return seen with no read in flight
module ram_4k_req_sched #(
  parameter int RAM_WIDTH  = 64,
  parameter int ADDR_SIZE  = 12,
  parameter int RESP_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_req_valid,
  output logic                 wr_req_ready,
  input  logic [ADDR_SIZE-1:0] wr_req_addr,
  input  logic [RAM_WIDTH-1:0] wr_req_data,
  input  logic                 rd_req_valid,
  output logic                 rd_req_ready,
  input  logic [ADDR_SIZE-1:0] rd_req_addr,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [RAM_WIDTH-1:0] rsp_data,
  output logic [RAM_WIDTH-1:0] ram_data_in,
  output logic [ADDR_SIZE-1:0] ram_wr_address,
  output logic [ADDR_SIZE-1:0] ram_rd_address,
  output logic                 ram_write,
  output logic                 ram_read,
  input  logic [RAM_WIDTH-1:0] ram_data_out,
  input  logic                 ram_data_valid,
  output logic                 err_stray_valid
);

  localparam int PW = $clog2(RESP_DEPTH);
  localparam int CW = PW + 1;  // counts need to reach RESP_DEPTH itself

  // Goes high on the first clock after reset release. It keeps both ready
  // outputs at 0 while reset is applied.
  logic          active_reg;
  logic [CW-1:0] inflight_reg;
  logic [CW-1:0] count_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;

  logic [RAM_WIDTH-1:0] fifo_mem [RESP_DEPTH];

  logic        hazard;
  logic        credit_ok;
  logic        wr_acc;
  logic        rd_acc;
  logic        ret;
  logic        push;
  logic        pop;
  logic [CW:0] occupancy;

  // A read to the address being written in the same cycle is held off one
  // cycle. The read then samples the RAM after the write has landed.
  assign hazard    = rd_req_valid && wr_req_valid && (rd_req_addr == wr_req_addr);
  assign occupancy = {1'b0, inflight_reg} + {1'b0, count_reg};
  assign credit_ok = occupancy < (CW + 1)'(RESP_DEPTH);

  assign wr_req_ready = active_reg;
  assign rd_req_ready = active_reg && credit_ok && !hazard;

  assign wr_acc = wr_req_valid && wr_req_ready;
  assign rd_acc = rd_req_valid && rd_req_ready;

  // A return is only honoured while a read is outstanding. A stray one is
  // dropped and flagged.
  assign ret  = ram_data_valid && (inflight_reg != '0);
  assign push = ret;

  assign rsp_valid = (count_reg != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_data  = rsp_valid ? fifo_mem[rd_ptr_reg] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_reg      <= 1'b0;
      ram_write       <= 1'b0;
      ram_read        <= 1'b0;
      ram_wr_address  <= '0;
      ram_rd_address  <= '0;
      ram_data_in     <= '0;
      inflight_reg    <= '0;
      count_reg       <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      err_stray_valid <= 1'b0;
    end else begin
      active_reg <= 1'b1;

      ram_write <= wr_acc;
      if (wr_acc) begin
        ram_wr_address <= wr_req_addr;
        ram_data_in    <= wr_req_data;
      end

      ram_read <= rd_acc;
      if (rd_acc) begin
        ram_rd_address <= rd_req_addr;
      end

      if (rd_acc && !ret) begin
        inflight_reg <= inflight_reg + CW'(1);
      end else if (!rd_acc && ret) begin
        inflight_reg <= inflight_reg - CW'(1);
      end

      if (push && !pop) begin
        count_reg <= count_reg + CW'(1);
      end else if (!push && pop) begin
        count_reg <= count_reg - CW'(1);
      end

      // The depth is a power of two, so the pointers wrap naturally.
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end

      if (ram_data_valid && (inflight_reg == '0)) begin
        err_stray_valid <= 1'b1;
      end
    end
  end

  // The storage has no reset. Its contents are only visible through count_reg.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= ram_data_out;
    end
  end

endmodule
